mmio_hub: RTL and testbench

- Parametrised memory-map hub between `proc` data port, `dmem` and on-board I/O; successor to the single-LED/single-switch top-level decode.
- Gates the dmem write enable and decodes an MMIO window at MMIO_BASE.
- MMIO window holds NUM_OUT output registers, a synchronised input port with sticky edge flags, and a prescaled compare timer.
- Merges all read data into one return path with selectable read latency and drives a level interrupt.

---
 rtl/mmio_pkg.sv | 18 +
 rtl/mmio_timer.sv | 85 ++++++++
 rtl/mmio_hub.sv | 139 +++++++++++++
 tb/tb_mmio_hub.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO hub: register offsets inside the 64-word
// window and bit positions in the timer control register.
package mmio_pkg;

  localparam logic [5:0] OFF_OUT   = 6'h00;  // output regs occupy OFF_OUT..OFF_OUT+NUM_OUT-1
  localparam logic [5:0] OFF_IN    = 6'h10;
  localparam logic [5:0] OFF_EDGE  = 6'h11;
  localparam logic [5:0] OFF_MASK  = 6'h12;
  localparam logic [5:0] OFF_TCNT  = 6'h20;
  localparam logic [5:0] OFF_TCMP  = 6'h21;
  localparam logic [5:0] OFF_TCTRL = 6'h22;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_AUTO  = 1;
  localparam int unsigned CTRL_IRQEN = 2;
  localparam int unsigned CTRL_EXP   = 15;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled compare timer.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   we_cmp         write strobe for the compare register
//   we_ctrl        write strobe for the control register
//   wdata          write data
//   count          current count (read value)
//   compare        compare value (read value)
//   ctrl           control read value {EXP, 12'b0, IRQEN, AUTO, EN}
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int unsigned PRESCALE = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_cmp,
  input  logic        we_ctrl,
  input  logic [15:0] wdata,
  output logic [15:0] count,
  output logic [15:0] compare,
  output logic [15:0] ctrl
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;
  logic          en;
  logic          auto_on;
  logic          irqen;
  logic          exp_flag;
  logic          tick;
  logic          match;

  assign tick  = en && (psc == PSC_LAST);
  assign match = (count == compare);

  // Prescaler is held at zero whenever the timer is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       psc <= '0;
    else if (!en)  psc <= '0;
    else if (tick) psc <= '0;
    else           psc <= psc + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      compare  <= '0;
      en       <= 1'b0;
      auto_on  <= 1'b0;
      irqen    <= 1'b0;
      exp_flag <= 1'b0;
    end else begin
      if (we_cmp) compare <= wdata;
      if (we_ctrl) begin
        auto_on <= wdata[CTRL_AUTO];
        irqen   <= wdata[CTRL_IRQEN];
      end
      // One-shot stop on a compare hit overrides a same-cycle software EN write.
      if (tick && match && !auto_on) en <= 1'b0;
      else if (we_ctrl)              en <= wdata[CTRL_EN];
      // Hardware set of EXP wins over a same-cycle W1C.
      if (tick && match)                      exp_flag <= 1'b1;
      else if (we_ctrl && wdata[CTRL_EXP])    exp_flag <= 1'b0;
      // A tick needs EN=1, so it never coincides with the EN 0->1 count clear.
      if (tick) begin
        if (!match)      count <= count + 16'd1;
        else if (auto_on) count <= '0;
      end else if (we_ctrl && !en && wdata[CTRL_EN]) begin
        count <= '0;
      end
    end
  end

  always_comb begin
    ctrl             = '0;
    ctrl[CTRL_EN]    = en;
    ctrl[CTRL_AUTO]  = auto_on;
    ctrl[CTRL_IRQEN] = irqen;
    ctrl[CTRL_EXP]   = exp_flag;
  end

endmodule

// File: rtl/mmio_hub.sv
// Memory-map hub between the processor data port, data memory and on-board
// I/O. Gates the dmem write enable, decodes a 64-word MMIO window holding
// output registers, a synchronised input port with sticky edge flags and a
// compare timer, merges read data and drives a registered level interrupt.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   daddr_i        processor data address
//   we_i           processor write strobe
//   wdata_i        processor write data
//   dmem_rdata_i   data memory read data
//   dmem_we_o      gated data memory write enable
//   rdata_o        read data returned to the processor
//   gpio_out_o     output registers concatenated, reg 0 in the LSBs
//   gpio_in_i      asynchronous inputs
//   irq_o          level interrupt
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = 13,
  parameter logic [15:0] MMIO_BASE  = 16'hC000,
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned OUT_W      = 10,
  parameter int unsigned IN_W       = 10,
  parameter int unsigned PRESCALE   = 50,
  parameter int unsigned READ_LAT   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              daddr_i,
  input  logic                     we_i,
  input  logic [15:0]              wdata_i,
  input  logic [15:0]              dmem_rdata_i,
  output logic                     dmem_we_o,
  output logic [15:0]              rdata_o,
  output logic [NUM_OUT*OUT_W-1:0] gpio_out_o,
  input  logic [IN_W-1:0]          gpio_in_i,
  output logic                     irq_o
);

  logic             hit;
  logic [5:0]       off;
  logic             wr;
  logic [OUT_W-1:0] out_reg [NUM_OUT];
  logic [IN_W-1:0]  sync1, sync2, prev, flags, mask, rise, w1c;
  logic [15:0]      tcount, tcompare, tctrl;
  logic [15:0]      mmio_val;

  assign dmem_we_o = we_i & ~|daddr_i[15:DMEM_DEPTH];
  assign hit       = (daddr_i[15:6] == MMIO_BASE[15:6]);
  assign off       = daddr_i[5:0];
  assign wr        = we_i & hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) out_reg[k] <= '0;
    end else if (wr) begin
      for (int unsigned k = 0; k < NUM_OUT; k++)
        if (off == OFF_OUT + 6'(k)) out_reg[k] <= wdata_i[OUT_W-1:0];
    end
  end

  always_comb begin
    gpio_out_o = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) gpio_out_o[k*OUT_W +: OUT_W] = out_reg[k];
  end

  // Edge set is OR-ed after the W1C mask so a coincident rise keeps the flag.
  assign rise = sync2 & ~prev;
  assign w1c  = (wr && off == OFF_EDGE) ? wdata_i[IN_W-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      flags <= '0;
      mask  <= '0;
    end else begin
      sync1 <= gpio_in_i;
      sync2 <= sync1;
      prev  <= sync2;
      flags <= (flags & ~w1c) | rise;
      if (wr && off == OFF_MASK) mask <= wdata_i[IN_W-1:0];
    end
  end

  mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .we_cmp  (wr && off == OFF_TCMP),
    .we_ctrl (wr && off == OFF_TCTRL),
    .wdata   (wdata_i),
    .count   (tcount),
    .compare (tcompare),
    .ctrl    (tctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_o <= 1'b0;
    else     irq_o <= (|(flags & mask)) | (tctrl[CTRL_EXP] & tctrl[CTRL_IRQEN]);
  end

  always_comb begin
    mmio_val = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++)
      if (off == OFF_OUT + 6'(k)) mmio_val[OUT_W-1:0] = out_reg[k];
    case (off)
      OFF_IN:    mmio_val[IN_W-1:0] = sync2;
      OFF_EDGE:  mmio_val[IN_W-1:0] = flags;
      OFF_MASK:  mmio_val[IN_W-1:0] = mask;
      OFF_TCNT:  mmio_val = tcount;
      OFF_TCMP:  mmio_val = tcompare;
      OFF_TCTRL: mmio_val = tctrl;
      default:   ;
    endcase
  end

  generate
    if (READ_LAT == 0) begin : g_comb_read
      assign rdata_o = hit ? mmio_val : dmem_rdata_i;
    end else begin : g_reg_read
      // MMIO data is captured at the address cycle; dmem data arrives live
      // one cycle later from the synchronous memory.
      logic        hit_q;
      logic [15:0] val_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hit_q <= 1'b0;
          val_q <= '0;
        end else begin
          hit_q <= hit;
          val_q <= mmio_val;
        end
      end
      assign rdata_o = hit_q ? val_q : dmem_rdata_i;
    end
  endgenerate

endmodule

// File: tb/tb_mmio_hub.sv
// Bench for mmio_hub: two instances (combinational and registered read)
// share stimulus; a cycle-level behavioural model supplies expectations.
module tb_mmio_hub;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] daddr = '0, wdata = '0, dmem_rdata = '0;
  logic        we = 1'b0;
  logic [9:0]  gin = '0;

  logic        dwe0, dwe1, irq0, irq1;
  logic [15:0] rd0, rd1;
  logic [19:0] gout0, gout1;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  mmio_hub #(.PRESCALE(P), .READ_LAT(0)) u0 (
    .clk(clk), .rst(rst), .daddr_i(daddr), .we_i(we), .wdata_i(wdata),
    .dmem_rdata_i(dmem_rdata), .dmem_we_o(dwe0), .rdata_o(rd0),
    .gpio_out_o(gout0), .gpio_in_i(gin), .irq_o(irq0));

  mmio_hub #(.PRESCALE(P), .READ_LAT(1)) u1 (
    .clk(clk), .rst(rst), .daddr_i(daddr), .we_i(we), .wdata_i(wdata),
    .dmem_rdata_i(dmem_rdata), .dmem_we_o(dwe1), .rdata_o(rd1),
    .gpio_out_o(gout1), .gpio_in_i(gin), .irq_o(irq1));

  // Behavioural model state; seenN is the input as sampled N edges ago.
  logic [15:0] m_out [2];
  logic [9:0]  seen1, seen2, seen3, m_flags, m_mask;
  logic [15:0] m_cnt, m_cmp, m_lval;
  bit          m_en, m_auto, m_irqen, m_exp, m_irq, m_lhit;
  int          m_psc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ntests++;
    assert (obs === exp_v)
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit is_hit(input logic [15:0] a);
    return (a >> 6) == (16'hC000 >> 6);
  endfunction

  function automatic logic [15:0] m_read(input logic [5:0] o);
    case (o)
      6'h00:   return m_out[0];
      6'h01:   return m_out[1];
      6'h10:   return {6'b0, seen2};
      6'h11:   return {6'b0, m_flags};
      6'h12:   return {6'b0, m_mask};
      6'h20:   return m_cnt;
      6'h21:   return m_cmp;
      6'h22:   return {m_exp, 12'b0, m_irqen, m_auto, m_en};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_reset();
    m_out[0] = '0; m_out[1] = '0;
    seen1 = '0; seen2 = '0; seen3 = '0; m_flags = '0; m_mask = '0;
    m_cnt = '0; m_cmp = '0; m_lval = '0; m_psc = 0;
    m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0; m_irq = 0; m_lhit = 0;
  endtask

  // Advance one clock: evaluate the rules on pre-edge state, then commit.
  task automatic step();
    bit          wr, tick;
    logic [5:0]  o;
    logic [15:0] n_out0, n_out1, n_cnt, n_cmp, n_lval;
    logic [9:0]  n_flags, n_mask, clr;
    bit          n_en, n_auto, n_irqen, n_exp, n_irq, n_lhit;
    int          n_psc;
    wr = we && is_hit(daddr);
    o  = daddr[5:0];
    n_out0 = (wr && o == 0) ? (wdata & 16'h03FF) : m_out[0];
    n_out1 = (wr && o == 1) ? (wdata & 16'h03FF) : m_out[1];
    clr     = (wr && o == 6'h11) ? wdata[9:0] : 10'h000;
    n_flags = (m_flags & ~clr) | (seen2 & ~seen3);
    n_mask  = (wr && o == 6'h12) ? wdata[9:0] : m_mask;
    n_cmp   = (wr && o == 6'h21) ? wdata : m_cmp;
    tick  = m_en && (m_psc == P - 1);
    n_psc = !m_en ? 0 : (tick ? 0 : m_psc + 1);
    n_cnt = m_cnt; n_en = m_en; n_auto = m_auto; n_irqen = m_irqen; n_exp = m_exp;
    if (wr && o == 6'h22) begin
      n_en = wdata[0]; n_auto = wdata[1]; n_irqen = wdata[2];
      if (wdata[15]) n_exp = 0;
      if (!m_en && wdata[0]) n_cnt = 0;
    end
    if (tick) begin
      if (m_cnt == m_cmp) begin
        n_exp = 1;
        if (m_auto) n_cnt = 0;
        else        n_en = 0;
      end else begin
        n_cnt = m_cnt + 16'd1;
      end
    end
    n_irq  = ((m_flags & m_mask) != 0) || (m_exp && m_irqen);
    n_lhit = is_hit(daddr);
    n_lval = m_read(o);
    @(posedge clk);
    #1;
    m_out[0] = n_out0; m_out[1] = n_out1;
    seen3 = seen2; seen2 = seen1; seen1 = gin;
    m_flags = n_flags; m_mask = n_mask; m_cmp = n_cmp; m_cnt = n_cnt; m_psc = n_psc;
    m_en = n_en; m_auto = n_auto; m_irqen = n_irqen; m_exp = n_exp;
    m_irq = n_irq; m_lhit = n_lhit; m_lval = n_lval;
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".dwe0"}, 32'(dwe0), 32'(we && (daddr >> 13) == 0));
    chk({tag, ".dwe1"}, 32'(dwe1), 32'(we && (daddr >> 13) == 0));
    chk({tag, ".gout0"}, 32'(gout0), {12'b0, m_out[1][9:0], m_out[0][9:0]});
    chk({tag, ".gout1"}, 32'(gout1), {12'b0, m_out[1][9:0], m_out[0][9:0]});
    chk({tag, ".irq0"}, 32'(irq0), 32'(m_irq));
    chk({tag, ".irq1"}, 32'(irq1), 32'(m_irq));
    chk({tag, ".rd0"}, 32'(rd0), 32'(is_hit(daddr) ? m_read(daddr[5:0]) : dmem_rdata));
    chk({tag, ".rd1"}, 32'(rd1), 32'(m_lhit ? m_lval : dmem_rdata));
  endtask

  task automatic cyc(input string tag);
    check_all(tag);
    step();
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [15:0] d, input string tag);
    we = 1'b1; daddr = a; wdata = d;
    cyc(tag);
    we = 1'b0;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 10))
      0:  return 16'hC000;
      1:  return 16'hC001;
      2:  return 16'hC002;
      3:  return 16'hC010;
      4:  return 16'hC011;
      5:  return 16'hC012;
      6:  return 16'hC020;
      7:  return 16'hC021;
      8:  return 16'hC022;
      9:  return 16'hC03F;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    m_reset();
    check_all("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Output registers
    wr_reg(16'hC000, 16'h03FF, "out0");
    wr_reg(16'hC001, 16'h0155, "out1");
    daddr = 16'hC001;
    #1;
    chk("gout_const", 32'(gout0), 32'h557FF);
    chk("rd_out1_const", 32'(rd0), 32'h0155);
    cyc("rd_out1");

    // dmem gating and read pass-through
    wr_reg(16'h1FFF, 16'h1234, "dmem_top");
    wr_reg(16'h2000, 16'h4321, "not_dmem");
    daddr = 16'h0100; dmem_rdata = 16'hBEEF;
    cyc("dmem_rd");
    cyc("dmem_rd_lat");
    chk("rd1_dmem_const", 32'(rd1), 32'hBEEF);

    // Input sync, edge flags, mask
    gin = 10'h201; daddr = 16'hC010;
    repeat (3) cyc("sync");
    chk("sync_const", 32'(rd0), 32'h0201);
    daddr = 16'hC011;
    cyc("edge");
    wr_reg(16'hC012, 16'h0001, "mask");
    daddr = 16'hC011;
    repeat (2) cyc("irq_edge");
    gin = 10'h200;
    wr_reg(16'hC011, 16'h0001, "w1c0");
    daddr = 16'hC011;
    repeat (4) cyc("low");
    gin = 10'h201;
    repeat (2) cyc("rerise");
    wr_reg(16'hC011, 16'h0001, "w1c_race");
    daddr = 16'hC011;
    #1 chk("w1c_race_const", 32'(rd0[0]), 32'h1);
    cyc("after_race");
    wr_reg(16'hC012, 16'h0000, "mask_off");
    wr_reg(16'hC011, 16'h03FF, "w1c_all");

    // Timer, auto-reload
    wr_reg(16'hC021, 16'h0003, "cmp3");
    wr_reg(16'hC022, 16'h0007, "ctrl7");
    daddr = 16'hC020;
    repeat (20) cyc("auto_run");
    chk("auto_irq_const", 32'(irq0), 32'h1);
    wr_reg(16'hC022, 16'h8000, "exp_w1c");
    daddr = 16'hC022;
    repeat (3) cyc("after_w1c");

    // Timer, one-shot
    wr_reg(16'hC021, 16'h0002, "cmp2");
    wr_reg(16'hC022, 16'h0005, "ctrl5");
    daddr = 16'hC022;
    repeat (20) cyc("oneshot");
    chk("oneshot_ctrl_const", 32'(rd0), 32'h8004);
    daddr = 16'hC020;
    #1 chk("oneshot_cnt_const", 32'(rd0), 32'h0002);

    // Asynchronous reset mid-count with EXP set and inputs high
    wr_reg(16'hC022, 16'h0003, "restart");
    gin = 10'h3FF; daddr = 16'hC022; dmem_rdata = 16'h0000;
    repeat (6) cyc("pre_rst");
    rst = 1'b1;
    #1;
    chk("arst_gout", 32'(gout0), 32'h0);
    chk("arst_irq", 32'(irq0), 32'h0);
    chk("arst_rd0", 32'(rd0), 32'h0);
    chk("arst_rd1", 32'(rd1), 32'h0);
    m_reset();
    check_all("in_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    daddr = 16'hC011;
    repeat (5) cyc("post_rst");
    chk("post_rst_flags_const", 32'(rd0), 32'h03FF);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      daddr = pick_addr();
      we = ($urandom_range(0, 2) == 0);
      wdata = 16'($urandom);
      dmem_rdata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) gin = 10'($urandom);
      cyc("rand");
    end
    we = 1'b0;
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
